mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between instruction fetch and data access.
// Data normally wins; a saturating counter lets a waiting fetch through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:2] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [11:2] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [11:2] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntD} state_e;

  state_e      state_q;
  logic [11:2] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [1:0]  starve_q;
  logic        if_ack_q, d_ack_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic if_elig, d_elig, starved, grant_d, grant_if;

  // A requester still high during its own ack cycle is not a new request.
  always_comb begin
    if_elig  = if_req && !if_ack_q;
    d_elig   = d_req && !d_ack_q;
    starved  = (32'(starve_q) == STARVE_MAX);
    grant_d  = d_elig && !(if_elig && starved);
    grant_if = if_elig && !grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q <= StGntD;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            if (if_req && starve_q != 2'd3) starve_q <= starve_q + 2'd1;
          end else if (grant_if) begin
            state_q  <= StGntIf;
            addr_q   <= if_addr;
            starve_q <= '0;
          end
        end
        StGntIf: begin
          state_q    <= StIdle;
          if_ack_q   <= 1'b1;
          if_rdata_q <= mem_dout;
        end
        StGntD: begin
          state_q   <= StIdle;
          d_ack_q   <= 1'b1;
          d_rdata_q <= mem_dout;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory-side signals derive from the async-reset state so a reset kills a store at once.
  always_comb begin
    busy     = (state_q != StIdle);
    mem_addr = busy ? addr_q : '0;
    mem_we   = (state_q == StGntD) && we_q;
    mem_din  = wdata_q;
    if_ack   = if_ack_q;
    d_ack    = d_ack_q;
    if_rdata = if_rdata_q;
    d_rdata  = d_rdata_q;
  end

endmodule
